// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between memory stage and data RAM responder
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        read_write;
  logic [1:0]  access_size;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        fault;
  modport master (
    output req_valid, read_write, access_size, address, data_in,
    input  req_ready, resp_valid, data_out, fault
  );
  modport slave (
    input  req_valid, read_write, access_size, address, data_in,
    output req_ready, resp_valid, data_out, fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte-addressed word RAM with lane select, alignment and range faults
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
  input logic             clock,
  input logic             reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        rw_q;
  logic [1:0]  sz_q;
  logic [31:0] addr_q, din_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, word, rd, ld, wd;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        flt, commit;
  // decode the captured request: word index, lane, fault, read alignment and write lanes
  always_comb begin
    off    = addr_q - BASE_ADDR;
    idx    = off[AW+1:2];
    lane   = off[1:0];
    flt    = (off >= 32'(DEPTH_WORDS) * 4) || (sz_q == 2'b11) ||
             (sz_q == 2'b01 && off[0]) || (sz_q == 2'b10 && lane != 2'b00);
    word   = mem[idx];
    rd     = word >> {lane, 3'b000};
    ld     = sz_q == 2'b00 ? {24'h0, rd[7:0]} : sz_q == 2'b01 ? {16'h0, rd[15:0]} : rd;
    be     = sz_q == 2'b00 ? 4'b0001 << lane : sz_q == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    wd     = sz_q == 2'b00 ? {4{din_q[7:0]}} : sz_q == 2'b01 ? {2{din_q[15:0]}} : din_q;
    commit = (state == BUSY) && (cnt == 4'd0);
  end
  // request FSM with registered handshake and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.data_out   <= 32'h0;
      bus.fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          rw_q          <= bus.read_write;
          sz_q          <= bus.access_size;
          addr_q        <= bus.address;
          din_q         <= bus.data_in;
          cnt           <= 4'(LATENCY - 1);
          state         <= BUSY;
          bus.req_ready <= 1'b0;
        end
        BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.data_out   <= (flt || rw_q) ? 32'h0 : ld;
          bus.fault      <= flt;
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
  // byte-enable store at the commit edge; reset on the same edge cancels it
  always_ff @(posedge clock) begin
    if (!reset && commit && rw_q && !flt)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
